// File: rtl/osiris_pipe_pkg.sv
// -----------------------------------------------------------------------------
// osiris_pipe_pkg
// Shared types for the EX->MEM pipeline stage:
//   - XLEN / REG_IDX_W     : datapath and register-index widths of the payload
//   - ex_mem_payload_t     : every field carried from EX to MEM, packed so the
//                            generic skid buffer can hold it as a flat vector
//   - occ_state_e          : skid-buffer occupancy states (value == entries held)
//   - RESULT_SRC_*         : write-back result select encodings
//   - rf_write_en()        : register-file write qualifier (x0 suppression)
// -----------------------------------------------------------------------------
package osiris_pipe_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [1:0] RESULT_SRC_ALU = 2'd0;
    localparam logic [1:0] RESULT_SRC_MEM = 2'd1;
    localparam logic [1:0] RESULT_SRC_PC4 = 2'd2;

    // Encodings double as the occupancy count driven on o_occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic [XLEN-1:0]      alu_result;
        logic [XLEN-1:0]      write_data;
        logic [XLEN-1:0]      pc_plus4;
        logic [XLEN-1:0]      pc_target;
        logic [REG_IDX_W-1:0] rd;
        logic                 reg_write;
        logic [1:0]           result_src;
        logic                 mem_write;
        logic [2:0]           funct3;
    } ex_mem_payload_t;

    // Writes to x0 are architecturally discarded, so never let one reach the RF.
    function automatic logic rf_write_en(input logic valid, input ex_mem_payload_t pl);
        return valid & pl.reg_write & (pl.rd != '0);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Generic 2-entry skid buffer with synchronous flush. MAIN drives the output;
// SKID catches the one beat that arrives while the consumer stalls, which lets
// the upstream ready be a plain register without losing throughput.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush_i           drop both entries next cycle (same-cycle input discarded)
//   in_valid_i        upstream beat valid
//   in_ready_o        registered ready (low only when SKID is occupied)
//   in_data_i         upstream payload
//   out_valid_o       MAIN holds a beat (registered)
//   out_ready_i       downstream accepts MAIN
//   out_data_o        MAIN payload, stable while stalled
//   occupancy_o       entries held, 0..2
// -----------------------------------------------------------------------------
module pipe_skid_buf
    import osiris_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       occupancy_o
);

    occ_state_e       state_q;
    logic             valid_q;
    logic             ready_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    logic acc;
    logic drn;

    assign acc = in_valid_i & ready_q;
    assign drn = valid_q & out_ready_i;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            // NOTE: the payload entries are reset on purpose so every output
            // reads zero out of reset; this is a register pair, not a RAM.
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush_i) begin
            // Payload contents are left as-is; only the valid tracking is cleared.
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_q  <= in_data_i;
                        state_q <= ONE;
                        valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (acc && drn) begin
                        main_q  <= in_data_i;
                    end else if (acc) begin
                        // Consumer stalled: park the new beat, close the gate.
                        skid_q  <= in_data_i;
                        state_q <= FULL;
                        ready_q <= 1'b0;
                    end else if (drn) begin
                        state_q <= EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    // ready_q is low here, so no new beat can arrive.
                    if (drn) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = main_q;
    assign occupancy_o = state_q;

endmodule

// File: rtl/ex_mem_skid_stage.sv
// -----------------------------------------------------------------------------
// ex_mem_skid_stage
// EX->MEM pipeline register with valid/ready handshake, built on a 2-entry
// skid buffer so o_ready_EX is registered yet full throughput is kept under
// MEM back-pressure. Adds write-enable gating (x0 suppression, valid-qualified
// store enable) and optional performance counters.
//
// Optional feature: define EX_MEM_PERF_CNT_EN to add o_stall_cnt/o_bubble_cnt
// (saturating, cleared by rst only).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_flush                  synchronous flush (mispredict / trap)
//   i_valid_EX / o_ready_EX  EX-side handshake (ready is registered)
//   i_*_EX                   payload from execute
//   o_valid_M / i_ready_M    MEM-side handshake
//   o_*_M                    payload to memory stage, held while stalled
//   o_occupancy              entries held (0..2)
//   o_stall_cnt              [macro] cycles with o_valid_M & !i_ready_M
//   o_bubble_cnt             [macro] cycles with !o_valid_M
// -----------------------------------------------------------------------------
module ex_mem_skid_stage
    import osiris_pipe_pkg::*;
#(
`ifdef EX_MEM_PERF_CNT_EN
    parameter int CNT_WIDTH  = 16,
`endif
    parameter int DATA_WIDTH = XLEN,
    parameter int REG_WIDTH  = REG_IDX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,

    input  logic                  i_valid_EX,
    output logic                  o_ready_EX,
    input  logic [DATA_WIDTH-1:0] i_alu_result_EX,
    input  logic [DATA_WIDTH-1:0] i_write_data_EX,
    input  logic [DATA_WIDTH-1:0] i_pc_plus4_EX,
    input  logic [DATA_WIDTH-1:0] i_pc_target_EX,
    input  logic [REG_WIDTH-1:0]  i_rd_EX,
    input  logic                  i_reg_write_EX,
    input  logic [1:0]            i_result_src_EX,
    input  logic                  i_mem_write_EX,
    input  logic [2:0]            i_funct3_EX,

    output logic                  o_valid_M,
    input  logic                  i_ready_M,
    output logic [DATA_WIDTH-1:0] o_alu_result_M,
    output logic [DATA_WIDTH-1:0] o_write_data_M,
    output logic [DATA_WIDTH-1:0] o_pc_plus4_M,
    output logic [DATA_WIDTH-1:0] o_pc_target_M,
    output logic [REG_WIDTH-1:0]  o_rd_M,
    output logic                  o_reg_write_M,
    output logic [1:0]            o_result_src_M,
    output logic                  o_mem_write_M,
    output logic [2:0]            o_funct3_M,

`ifdef EX_MEM_PERF_CNT_EN
    output logic [CNT_WIDTH-1:0]  o_stall_cnt,
    output logic [CNT_WIDTH-1:0]  o_bubble_cnt,
`endif
    output logic [1:0]            o_occupancy
);

    // The packed payload is sized by the package; DATA_WIDTH / REG_WIDTH must
    // stay at the package values (XLEN / REG_IDX_W).
    ex_mem_payload_t in_pl;
    ex_mem_payload_t out_pl;

    assign in_pl = '{
        alu_result: i_alu_result_EX,
        write_data: i_write_data_EX,
        pc_plus4:   i_pc_plus4_EX,
        pc_target:  i_pc_target_EX,
        rd:         i_rd_EX,
        reg_write:  i_reg_write_EX,
        result_src: i_result_src_EX,
        mem_write:  i_mem_write_EX,
        funct3:     i_funct3_EX
    };

    pipe_skid_buf #(
        .WIDTH($bits(ex_mem_payload_t))
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (i_flush),
        .in_valid_i  (i_valid_EX),
        .in_ready_o  (o_ready_EX),
        .in_data_i   (in_pl),
        .out_valid_o (o_valid_M),
        .out_ready_i (i_ready_M),
        .out_data_o  (out_pl),
        .occupancy_o (o_occupancy)
    );

    // Data fields pass straight through; only the side-effecting enables are
    // qualified by valid so a stale MAIN entry can never write anything.
    assign o_alu_result_M = out_pl.alu_result;
    assign o_write_data_M = out_pl.write_data;
    assign o_pc_plus4_M   = out_pl.pc_plus4;
    assign o_pc_target_M  = out_pl.pc_target;
    assign o_rd_M         = out_pl.rd;
    assign o_result_src_M = out_pl.result_src;
    assign o_funct3_M     = out_pl.funct3;
    assign o_reg_write_M  = rf_write_en(o_valid_M, out_pl);
    assign o_mem_write_M  = o_valid_M & out_pl.mem_write;

`ifdef EX_MEM_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (o_valid_M && !i_ready_M && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if (!o_valid_M && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Flush does not clear the counters; they only track observed stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign o_stall_cnt  = stall_cnt_q;
    assign o_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_mem_skid_stage
// Directed self-checking bench for ex_mem_skid_stage. Each beat k carries a
// payload derived from k so ordering, loss and duplication are visible.
// -----------------------------------------------------------------------------
module tb_ex_mem_skid_stage;
    import osiris_pipe_pkg::*;

    localparam int TB_CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_flush;
    logic        i_valid_EX;
    logic        o_ready_EX;
    logic [31:0] i_alu_result_EX, i_write_data_EX, i_pc_plus4_EX, i_pc_target_EX;
    logic [4:0]  i_rd_EX;
    logic        i_reg_write_EX;
    logic [1:0]  i_result_src_EX;
    logic        i_mem_write_EX;
    logic [2:0]  i_funct3_EX;
    logic        o_valid_M;
    logic        i_ready_M;
    logic [31:0] o_alu_result_M, o_write_data_M, o_pc_plus4_M, o_pc_target_M;
    logic [4:0]  o_rd_M;
    logic        o_reg_write_M;
    logic [1:0]  o_result_src_M;
    logic        o_mem_write_M;
    logic [2:0]  o_funct3_M;
    logic [1:0]  o_occupancy;
`ifdef EX_MEM_PERF_CNT_EN
    logic [TB_CNT_W-1:0] o_stall_cnt;
    logic [TB_CNT_W-1:0] o_bubble_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_mem_skid_stage #(
`ifdef EX_MEM_PERF_CNT_EN
        .CNT_WIDTH (TB_CNT_W),
`endif
        .DATA_WIDTH(32),
        .REG_WIDTH (5)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_flush         (i_flush),
        .i_valid_EX      (i_valid_EX),
        .o_ready_EX      (o_ready_EX),
        .i_alu_result_EX (i_alu_result_EX),
        .i_write_data_EX (i_write_data_EX),
        .i_pc_plus4_EX   (i_pc_plus4_EX),
        .i_pc_target_EX  (i_pc_target_EX),
        .i_rd_EX         (i_rd_EX),
        .i_reg_write_EX  (i_reg_write_EX),
        .i_result_src_EX (i_result_src_EX),
        .i_mem_write_EX  (i_mem_write_EX),
        .i_funct3_EX     (i_funct3_EX),
        .o_valid_M       (o_valid_M),
        .i_ready_M       (i_ready_M),
        .o_alu_result_M  (o_alu_result_M),
        .o_write_data_M  (o_write_data_M),
        .o_pc_plus4_M    (o_pc_plus4_M),
        .o_pc_target_M   (o_pc_target_M),
        .o_rd_M          (o_rd_M),
        .o_reg_write_M   (o_reg_write_M),
        .o_result_src_M  (o_result_src_M),
        .o_mem_write_M   (o_mem_write_M),
        .o_funct3_M      (o_funct3_M),
`ifdef EX_MEM_PERF_CNT_EN
        .o_stall_cnt     (o_stall_cnt),
        .o_bubble_cnt    (o_bubble_cnt),
`endif
        .o_occupancy     (o_occupancy)
    );

    // Payload model for beat k.
    function automatic logic [31:0] exp_alu(input int k);
        return 32'h1000_0000 + 32'(k);
    endfunction

    function automatic logic [31:0] exp_wdata(input int k);
        return 32'hA5A5_0000 ^ 32'(k * 3);
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int k);
        i_valid_EX      = 1'b1;
        i_alu_result_EX = exp_alu(k);
        i_write_data_EX = exp_wdata(k);
        i_pc_plus4_EX   = 32'(4 * k + 4);
        i_pc_target_EX  = 32'h8000_0000 + 32'(16 * k);
        i_rd_EX         = 5'(k);
        i_reg_write_EX  = 1'b1;
        i_result_src_EX = 2'(k % 3);
        i_mem_write_EX  = k[0];
        i_funct3_EX     = 3'(k);
    endtask

    task automatic idle_inputs();
        i_valid_EX      = 1'b0;
        i_alu_result_EX = '0;
        i_write_data_EX = '0;
        i_pc_plus4_EX   = '0;
        i_pc_target_EX  = '0;
        i_rd_EX         = '0;
        i_reg_write_EX  = 1'b0;
        i_result_src_EX = RESULT_SRC_ALU;
        i_mem_write_EX  = 1'b0;
        i_funct3_EX     = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_flush = 1'b0; i_ready_M = 1'b0;
        idle_inputs();
        cyc(); cyc();
        n_checks++; if (o_valid_M !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid_M); end
        n_checks++; if (o_ready_EX !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready_EX); end
        n_checks++; if (o_occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", o_occupancy); end
        n_checks++; if (o_alu_result_M !== 32'h0) begin n_fail++; $display("FAIL reset_alu: got %h want 0", o_alu_result_M); end
`ifdef EX_MEM_PERF_CNT_EN
        n_checks++; if (o_stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", o_stall_cnt); end
        n_checks++; if (o_bubble_cnt !== '0) begin n_fail++; $display("FAIL reset_bubble_cnt: got %0d want 0", o_bubble_cnt); end
`endif
        rst = 1'b0;
        cyc();
    endtask

    // T1: streaming with MEM always ready -- one beat per cycle, latency 1.
    task automatic test_stream();
        i_ready_M = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            set_beat(k);
            cyc();
            n_checks++; if (o_valid_M !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", k, o_valid_M); end
            n_checks++; if (o_alu_result_M !== exp_alu(k)) begin n_fail++; $display("FAIL stream_alu[%0d]: got %h want %h", k, o_alu_result_M, exp_alu(k)); end
            n_checks++; if (o_write_data_M !== exp_wdata(k)) begin n_fail++; $display("FAIL stream_wdata[%0d]: got %h want %h", k, o_write_data_M, exp_wdata(k)); end
            n_checks++; if (o_occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d want 1", k, o_occupancy); end
            n_checks++; if (o_mem_write_M !== k[0]) begin n_fail++; $display("FAIL stream_memwr[%0d]: got %b want %b", k, o_mem_write_M, k[0]); end
            n_checks++; if (o_funct3_M !== 3'(k)) begin n_fail++; $display("FAIL stream_funct3[%0d]: got %0d want %0d", k, o_funct3_M, 3'(k)); end
        end
        idle_inputs();
        cyc();
        n_checks++; if (o_valid_M !== 1'b0) begin n_fail++; $display("FAIL stream_drain_valid: got %b want 0", o_valid_M); end
        n_checks++; if (o_occupancy !== 2'd0) begin n_fail++; $display("FAIL stream_drain_occ: got %0d want 0", o_occupancy); end
    endtask

    // T2: back-pressure fills SKID, then A and B drain on consecutive cycles.
    task automatic test_back_to_back();
        i_ready_M = 1'b0;
        set_beat(20); cyc();
        n_checks++; if (o_occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_occ_a: got %0d want 1", o_occupancy); end
        n_checks++; if (o_ready_EX !== 1'b1) begin n_fail++; $display("FAIL bp_ready_a: got %b want 1", o_ready_EX); end
        set_beat(21); cyc();
        n_checks++; if (o_occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_occ_full: got %0d want 2", o_occupancy); end
        n_checks++; if (o_ready_EX !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", o_ready_EX); end
        n_checks++; if (o_alu_result_M !== exp_alu(20)) begin n_fail++; $display("FAIL bp_main_a: got %h want %h", o_alu_result_M, exp_alu(20)); end
        // Upstream keeps a third beat valid; ready is low so it must not enter.
        set_beat(22); cyc();
        n_checks++; if (o_alu_result_M !== exp_alu(20)) begin n_fail++; $display("FAIL bp_hold_a: got %h want %h", o_alu_result_M, exp_alu(20)); end
        n_checks++; if (o_occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_hold_occ: got %0d want 2", o_occupancy); end
        idle_inputs();
        i_ready_M = 1'b1;
        cyc();
        n_checks++; if (o_alu_result_M !== exp_alu(21) || o_valid_M !== 1'b1) begin n_fail++; $display("FAIL bp_drain_b: got %h/%b want %h/1", o_alu_result_M, o_valid_M, exp_alu(21)); end
        n_checks++; if (o_ready_EX !== 1'b1) begin n_fail++; $display("FAIL bp_ready_reopen: got %b want 1", o_ready_EX); end
        n_checks++; if (o_occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_occ_one: got %0d want 1", o_occupancy); end
        cyc();
        n_checks++; if (o_valid_M !== 1'b0) begin n_fail++; $display("FAIL bp_empty_valid: got %b want 0", o_valid_M); end
        n_checks++; if (o_occupancy !== 2'd0) begin n_fail++; $display("FAIL bp_empty_occ: got %0d want 0", o_occupancy); end
    endtask

    // T3: flush from FULL and from ONE with a same-cycle accepted beat.
    task automatic test_flush();
        i_ready_M = 1'b0;
        set_beat(30); cyc();
        set_beat(31); cyc();
        set_beat(32); i_flush = 1'b1;
        cyc();
        n_checks++; if (o_valid_M !== 1'b0) begin n_fail++; $display("FAIL flush_full_valid: got %b want 0", o_valid_M); end
        n_checks++; if (o_ready_EX !== 1'b1) begin n_fail++; $display("FAIL flush_full_ready: got %b want 1", o_ready_EX); end
        n_checks++; if (o_occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_full_occ: got %0d want 0", o_occupancy); end
        i_flush = 1'b0; idle_inputs(); i_ready_M = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            n_checks++; if (o_valid_M !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[%0d]: got valid %b alu %h want 0", c, o_valid_M, o_alu_result_M); end
        end
        // ONE state: beat 34 is accepted in the flush cycle and must be dropped.
        i_ready_M = 1'b0;
        set_beat(33); cyc();
        set_beat(34); i_flush = 1'b1; i_ready_M = 1'b1;
        cyc();
        n_checks++; if (o_valid_M !== 1'b0 || o_occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_one: got valid %b occ %0d want 0/0", o_valid_M, o_occupancy); end
        i_flush = 1'b0; idle_inputs();
        cyc();
        n_checks++; if (o_valid_M !== 1'b0) begin n_fail++; $display("FAIL flush_one_ghost: got %b want 0", o_valid_M); end
    endtask

    // T4: rd = x0 suppresses the RF write but not the data.
    task automatic test_x0_gating();
        i_ready_M = 1'b0;
        set_beat(5);
        i_rd_EX = 5'd0; i_reg_write_EX = 1'b1; i_mem_write_EX = 1'b1;
        i_alu_result_EX = 32'hDEAD_BEEF; i_result_src_EX = RESULT_SRC_MEM;
        cyc();
        n_checks++; if (o_reg_write_M !== 1'b0) begin n_fail++; $display("FAIL x0_regwrite: got %b want 0", o_reg_write_M); end
        n_checks++; if (o_alu_result_M !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL x0_alu: got %h want deadbeef", o_alu_result_M); end
        n_checks++; if (o_mem_write_M !== 1'b1) begin n_fail++; $display("FAIL x0_memwrite: got %b want 1", o_mem_write_M); end
        n_checks++; if (o_result_src_M !== RESULT_SRC_MEM) begin n_fail++; $display("FAIL x0_rsrc: got %0d want %0d", o_result_src_M, RESULT_SRC_MEM); end
        // Drain: enables drop with valid, payload register keeps its value.
        idle_inputs(); i_ready_M = 1'b1;
        cyc();
        n_checks++; if (o_mem_write_M !== 1'b0) begin n_fail++; $display("FAIL x0_memwrite_idle: got %b want 0", o_mem_write_M); end
        n_checks++; if (o_alu_result_M !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL x0_alu_kept: got %h want deadbeef", o_alu_result_M); end
        // Non-zero rd with reg_write does assert the RF write.
        set_beat(7); cyc();
        n_checks++; if (o_reg_write_M !== 1'b1) begin n_fail++; $display("FAIL rd7_regwrite: got %b want 1", o_reg_write_M); end
        idle_inputs(); cyc();
    endtask

    // T5: reset beats flush while FULL.
    task automatic test_reset_over_flush();
        i_ready_M = 1'b0;
        set_beat(40); cyc();
        set_beat(41); cyc();
        set_beat(42); rst = 1'b1; i_flush = 1'b1;
        cyc();
        n_checks++; if (o_valid_M !== 1'b0 || o_ready_EX !== 1'b1 || o_occupancy !== 2'd0) begin n_fail++; $display("FAIL rst_ctrl: got valid %b ready %b occ %0d want 0/1/0", o_valid_M, o_ready_EX, o_occupancy); end
        n_checks++; if (o_alu_result_M !== 32'h0 || o_write_data_M !== 32'h0 || o_pc_plus4_M !== 32'h0 || o_pc_target_M !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h %h %h %h want all 0", o_alu_result_M, o_write_data_M, o_pc_plus4_M, o_pc_target_M); end
        n_checks++; if (o_rd_M !== 5'd0 || o_reg_write_M !== 1'b0 || o_mem_write_M !== 1'b0 || o_funct3_M !== 3'd0 || o_result_src_M !== 2'd0) begin n_fail++; $display("FAIL rst_ctl_fields: got rd %0d rw %b mw %b f3 %0d rs %0d want 0", o_rd_M, o_reg_write_M, o_mem_write_M, o_funct3_M, o_result_src_M); end
        rst = 1'b0; i_flush = 1'b0; idle_inputs();
        cyc();
        n_checks++; if (o_valid_M !== 1'b0) begin n_fail++; $display("FAIL rst_after_valid: got %b want 0", o_valid_M); end
    endtask

`ifdef EX_MEM_PERF_CNT_EN
    // T6: stall counter saturates; flush does not clear counters.
    task automatic test_perf_counters();
        rst = 1'b1; i_flush = 1'b0; i_ready_M = 1'b0; idle_inputs();
        cyc();
        rst = 1'b0;
        set_beat(50);
        cyc();
        n_checks++; if (o_bubble_cnt !== 4'd1 || o_stall_cnt !== 4'd0) begin n_fail++; $display("FAIL perf_first: got bubble %0d stall %0d want 1/0", o_bubble_cnt, o_stall_cnt); end
        idle_inputs();
        repeat (20) cyc();
        n_checks++; if (o_stall_cnt !== 4'd15) begin n_fail++; $display("FAIL perf_stall_sat: got %0d want 15", o_stall_cnt); end
        n_checks++; if (o_bubble_cnt !== 4'd1) begin n_fail++; $display("FAIL perf_bubble_hold: got %0d want 1", o_bubble_cnt); end
        i_flush = 1'b1; cyc();
        i_flush = 1'b0; cyc();
        n_checks++; if (o_stall_cnt !== 4'd15 || o_bubble_cnt !== 4'd2) begin n_fail++; $display("FAIL perf_flush: got stall %0d bubble %0d want 15/2", o_stall_cnt, o_bubble_cnt); end
        rst = 1'b1; cyc();
        n_checks++; if (o_stall_cnt !== 4'd0 || o_bubble_cnt !== 4'd0) begin n_fail++; $display("FAIL perf_rst: got stall %0d bubble %0d want 0/0", o_stall_cnt, o_bubble_cnt); end
        rst = 1'b0; cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_flush();
        test_x0_gating();
        test_reset_over_flush();
`ifdef EX_MEM_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
